// File: rtl/text_buf_pkg.sv
// Shared types and constants for the on-screen text buffer writer.
package text_buf_pkg;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StConvert,
    StWrite
  } state_e;

  localparam logic [6:0] BLANK_CHAR = 7'h20;
  localparam logic [6:0] ASCII_ZERO = 7'h30;

  // Largest value that fits in n decimal digits (10^n - 1).
  function automatic logic [31:0] max_for_digits(input logic [2:0] n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < 7; i++) begin
      if (i < int'(n)) p = p * 32'd10;
    end
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/char_buf_ram.sv
// 256x7 simple dual-port character RAM: synchronous write, registered read-first read.
module char_buf_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port and registered read; the read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_buf_writer.sv
// Converts "print N at (x,y)" commands to ASCII decimal and writes them into a 16x16 char buffer.
module text_buf_writer #(
  parameter int unsigned VALUE_W    = 14,
  parameter int unsigned MAX_DIGITS = 5,
  parameter logic [6:0]  BLANK_CHAR = text_buf_pkg::BLANK_CHAR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [7:0]         cmd_xy,
  input  logic [VALUE_W-1:0] cmd_value,
  input  logic [2:0]         cmd_digits,
  input  logic               cmd_blank_lz,
  output logic               done,
  input  logic [7:0]         char_xy,
  output logic [6:0]         char_code
);

  import text_buf_pkg::*;

  localparam int unsigned BCD_W = 4 * MAX_DIGITS;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;      // clear address, dabble step or digit index
  logic [7:0]         xy_q, xy_d;
  logic [2:0]         n_q, n_d;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               lz_q, lz_d;        // still inside the leading-zero run
  logic               done_q, done_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [2:0]         n_clamp;
  logic [31:0]        sat_max;
  logic [2:0]         nib_idx;
  logic [3:0]         nib;
  logic [4:0]         col;
  logic               last_digit;
  logic               ram_we;
  logic [7:0]         ram_waddr;
  logic [6:0]         ram_wdata;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(MAX_DIGITS); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Command digit clamp, saturation limit and write-stage digit selection.
  always_comb begin
    if (cmd_digits == 3'd0) begin
      n_clamp = 3'd1;
    end else if (cmd_digits > 3'(MAX_DIGITS)) begin
      n_clamp = 3'(MAX_DIGITS);
    end else begin
      n_clamp = cmd_digits;
    end
    sat_max    = max_for_digits(n_clamp);
    nib_idx    = n_q - 3'd1 - cnt_q[2:0];
    nib        = 4'd0;
    for (int k = 0; k < int'(MAX_DIGITS); k++) begin
      if (3'(k) == nib_idx) nib = bcd_q[4*k +: 4];
    end
    col        = {1'b0, xy_q[7:4]} + {2'b00, cnt_q[2:0]};
    last_digit = (cnt_q[2:0] == n_q - 3'd1);
  end

  // FSM next-state, datapath updates and buffer write port.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    xy_d      = xy_q;
    n_d       = n_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    lz_d      = lz_q;
    done_d    = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = cnt_q;
    ram_wdata = BLANK_CHAR;
    unique case (state_q)
      StClear: begin
        ram_we = 1'b1;
        if (cnt_q == 8'hFF) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StIdle: begin
        if (cmd_valid) begin
          xy_d  = cmd_xy;
          n_d   = n_clamp;
          bin_d = (32'(cmd_value) > sat_max) ? VALUE_W'(sat_max) : cmd_value;
          bcd_d = '0;
          lz_d  = cmd_blank_lz;
          cnt_d = 8'd0;
          state_d = StConvert;
        end
      end
      StConvert: begin
        {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
        if (cnt_q == 8'(VALUE_W - 1)) begin
          state_d = StWrite;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWrite: begin
        // Columns past 15 are dropped rather than wrapped; the cycle is still spent.
        ram_we    = ~col[4];
        ram_waddr = {col[3:0], xy_q[3:0]};
        if (lz_q && (nib == 4'd0) && !last_digit) begin
          ram_wdata = BLANK_CHAR;
        end else begin
          ram_wdata = ASCII_ZERO + {3'b000, nib};
          lz_d      = 1'b0;
        end
        if (last_digit) begin
          state_d = StIdle;
          done_d  = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // State registers; reset restarts the clear sweep from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= 8'd0;
      xy_q    <= 8'd0;
      n_q     <= 3'd1;
      bin_q   <= '0;
      bcd_q   <= '0;
      lz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xy_q    <= xy_d;
      n_q     <= n_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      lz_q    <= lz_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign done      = done_q;

  char_buf_ram #(
    .ADDR_W(8),
    .DATA_W(7)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we & ~rst),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(char_xy),
    .rdata(char_code)
  );

endmodule

// File: tb/tb_text_buf_writer.sv
// Directed bench for text_buf_writer with a reference buffer model and read-back scoreboard.
module tb_text_buf_writer;

  localparam int VALUE_W = 14;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [7:0]         cmd_xy = 8'h00;
  logic [VALUE_W-1:0] cmd_value = '0;
  logic [2:0]         cmd_digits = 3'd0;
  logic               cmd_blank_lz = 1'b0;
  logic               done;
  logic [7:0]         char_xy = 8'h00;
  logic [6:0]         char_code;

  int checks = 0;
  int failures = 0;

  logic [6:0] model [256];

  typedef struct {
    string      tag;
    logic [7:0] addr;
    logic [6:0] exp;
  } exp_t;

  exp_t sb[$];

  text_buf_writer #(
    .VALUE_W   (VALUE_W),
    .MAX_DIGITS(5),
    .BLANK_CHAR(7'h20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_xy      (cmd_xy),
    .cmd_value   (cmd_value),
    .cmd_digits  (cmd_digits),
    .cmd_blank_lz(cmd_blank_lz),
    .done        (done),
    .char_xy     (char_xy),
    .char_code   (char_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 7'h20;
  endtask

  // Reference: clamp, saturate, decimal digits by division, leading-zero blanking, column drop.
  task automatic model_cmd(input logic [7:0] xy, input int val, input int dig, input bit blz,
                           output int n);
    int  maxv, v, p, d, c;
    bit  lead;
    n    = (dig == 0) ? 1 : (dig > 5) ? 5 : dig;
    maxv = 1;
    for (int i = 0; i < n; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    v    = (val > maxv) ? maxv : val;
    lead = blz;
    for (int i = 0; i < n; i++) begin
      p = 1;
      for (int j = 0; j < n - 1 - i; j++) p = p * 10;
      d = (v / p) % 10;
      c = int'(xy[7:4]) + i;
      if (c <= 15) begin
        if (lead && d == 0 && i != n - 1) begin
          model[c * 16 + int'(xy[3:0])] = 7'h20;
        end else begin
          model[c * 16 + int'(xy[3:0])] = 7'(8'h30 + d);
          lead = 1'b0;
        end
      end
      if (!(lead && d == 0 && i != n - 1)) lead = 1'b0;
    end
  endtask

  task automatic push_row(input string tag, input int y);
    exp_t e;
    for (int x = 0; x < 16; x++) begin
      e.tag  = $sformatf("%s_cell%0h%0h", tag, x, y);
      e.addr = 8'(x * 16 + y);
      e.exp  = model[x * 16 + y];
      sb.push_back(e);
    end
  endtask

  task automatic read_back();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      char_xy = e.addr;
      @(posedge clk);
      #1;
      check(e.tag, 32'(char_code), 32'(e.exp));
    end
  endtask

  // Called at the negedge where rst was just released (cycle 1 of the clear sweep).
  task automatic wait_ready(input string tag);
    int cyc;
    bit bad_done;
    cyc = 1;
    bad_done = 1'b0;
    while (!cmd_ready && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done) bad_done = 1'b1;
    end
    check({tag, "_ready_cycle"}, 32'(cyc), 32'd257);
    check({tag, "_done_quiet"}, 32'(bad_done), 32'd0);
  endtask

  task automatic issue(input string tag, input logic [7:0] xy, input int val, input int dig,
                       input bit blz, input int abort_at);
    int n, k, guard;
    cmd_xy       = xy;
    cmd_value    = VALUE_W'(val);
    cmd_digits   = 3'(dig);
    cmd_blank_lz = blz;
    cmd_valid    = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready_before_accept"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    model_cmd(xy, val, dig, blz, n);
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
      if (k == 1) check({tag, "_ready_drop"}, 32'(cmd_ready), 32'd0);
      if (abort_at != 0 && k == abort_at) begin
        rst = 1'b1;
        return;
      end
    end
    check({tag, "_done_latency"}, 32'(k), 32'(VALUE_W + 1 + n));
    check({tag, "_ready_at_done"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    model_clear();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready_low", 32'(cmd_ready), 32'd0);
    check("reset_done_low", 32'(done), 32'd0);
    rst = 1'b0;
    wait_ready("init");
    for (int y = 0; y < 16; y++) push_row("init_blank", y);
    read_back();

    issue("v42", 8'h23, 42, 3, 1'b0, 0);
    push_row("v42", 3);
    read_back();

    issue("blz0", 8'h23, 0, 3, 1'b1, 0);
    push_row("blz0", 3);
    read_back();

    issue("blz7", 8'h23, 7, 3, 1'b1, 0);
    push_row("blz7", 3);
    read_back();

    issue("sat3", 8'h55, 16383, 3, 1'b0, 0);
    issue("dig0", 8'h66, 16383, 0, 1'b0, 0);
    issue("dig7", 8'h77, 16383, 7, 1'b0, 0);
    push_row("sat3", 5);
    push_row("dig0", 6);
    push_row("dig7", 7);
    read_back();

    issue("edge", 8'hE0, 1234, 4, 1'b0, 0);
    push_row("edge_row0", 0);
    push_row("edge_row1", 1);
    read_back();

    // Reset during the second write cycle, with a command held valid through the clear sweep.
    issue("abort", 8'h88, 555, 3, 1'b0, 16);
    @(negedge clk);
    rst          = 1'b0;
    cmd_xy       = 8'h09;
    cmd_value    = VALUE_W'(5);
    cmd_digits   = 3'd1;
    cmd_blank_lz = 1'b0;
    cmd_valid    = 1'b1;
    model_clear();
    wait_ready("abort_clear");
    issue("held", 8'h09, 5, 1, 1'b0, 0);
    push_row("post_abort", 8);
    push_row("held", 9);
    push_row("post_abort", 3);
    read_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
